// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_buf.sv
// One-entry response buffer: holds a completed read until the pipeline advances,
// and bypasses the memory data straight through in the completion cycle.
module mem_arb_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          clr,
  input  logic [DW-1:0] wdata,
  output logic          valid,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] data_q;

  // A clear in the same cycle as a write wins: the bypassed value was consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      data_q <= '0;
    end else begin
      if (wr) begin
        data_q <= wdata;
      end
      if (clr) begin
        valid <= 1'b0;
      end else if (wr) begin
        valid <= 1'b1;
      end
    end
  end

  assign rdata = wr ? wdata : data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one single-ported memory, data first,
// with per-port response buffers and combinational pipeline stalls.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          istall,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dstall,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  input  logic          mready
);

  arb_state_t state, next_state;
  logic ivalid, dvalid;
  logic ipend, dpend;
  logic idone, ddone;
  logic load_i, load_d;

  assign ipend = ireq & ~ivalid;
  assign dpend = dreq & ~dvalid;
  assign idone = (state == IBUSY) & mready;
  assign ddone = (state == DBUSY) & mready;

  assign istall = ipend & ~idone;
  assign dstall = dpend & ~ddone;

  // The access finishing this cycle is excluded so the next issue can go out back-to-back.
  always_comb begin
    next_state = state;
    load_i     = 1'b0;
    load_d     = 1'b0;
    unique case (state)
      IDLE, IBUSY, DBUSY: begin
        if ((state == IDLE) || mready) begin
          if (dpend && !ddone) begin
            next_state = DBUSY;
            load_d     = 1'b1;
          end else if (ipend && !idone) begin
            next_state = IBUSY;
            load_i     = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mreq   <= 1'b0;
      mwe    <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
    end else begin
      state <= next_state;
      mreq  <= (next_state != IDLE);
      if (load_d) begin
        maddr  <= daddr;
        mwe    <= dwe;
        mwdata <= dwdata;
      end else if (load_i) begin
        maddr <= iaddr;
        mwe   <= 1'b0;
      end
    end
  end

  mem_arb_buf #(.DW(DW)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .wr    (idone),
    .clr   (advance),
    .wdata (mrdata),
    .valid (ivalid),
    .rdata (irdata)
  );

  mem_arb_buf #(.DW(DW)) u_dbuf (
    .clk   (clk),
    .reset (reset),
    .wr    (ddone),
    .clr   (advance),
    .wdata (mrdata),
    .valid (dvalid),
    .rdata (drdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        advance;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        istall;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dstall;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [31:0] mrdata;
  logic        mready;

  int checkCount = 0;
  int passCount  = 0;
  int writeCount = 0;
  int lat        = 0;
  int cnt;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .ireq    (ireq),
    .iaddr   (iaddr),
    .irdata  (irdata),
    .istall  (istall),
    .dreq    (dreq),
    .dwe     (dwe),
    .daddr   (daddr),
    .dwdata  (dwdata),
    .drdata  (drdata),
    .dstall  (dstall),
    .mreq    (mreq),
    .mwe     (mwe),
    .maddr   (maddr),
    .mwdata  (mwdata),
    .mrdata  (mrdata),
    .mready  (mready)
  );

  // Memory model: word i preloads to 0x1000+i, except word 0 and word 0x10 (byte 0x40).
  always_comb mready = mreq && (cnt == lat);
  assign mrdata = mem[maddr[7:2]];

  always @(posedge clk) begin
    if (reset) begin
      cnt <= 0;
      for (int i = 0; i < 64; i++) begin
        mem[i] <= 32'h0000_1000 + i;
      end
      mem[0]  <= 32'h2002_0005;
      mem[16] <= 32'hDEAD_BEEF;
    end else if (mready) begin
      cnt <= 0;
      if (mwe) begin
        mem[maddr[7:2]] <= mwdata;
        writeCount <= writeCount + 1;
      end
    end else if (mreq) begin
      cnt <= cnt + 1;
    end
  end

  task automatic applyStimulus(input logic rst, input logic adv, input logic ir,
                               input logic [31:0] ia, input logic dr, input logic we,
                               input logic [31:0] da, input logic [31:0] wd);
    @(negedge clk);
    reset   = rst;
    advance = adv;
    ireq    = ir;
    iaddr   = ia;
    dreq    = dr;
    dwe     = we;
    daddr   = da;
    dwdata  = wd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; advance = 1'b0; ireq = 1'b1; iaddr = 32'h0;
    dreq = 1'b0; dwe = 1'b0; daddr = 32'h0; dwdata = 32'h0;
    repeat (2) @(posedge clk);

    // Reset state and the first fetch at L=0.
    applyStimulus(0, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("rst_mreq", mreq, 0);
    checkOutput("rst_mwe", mwe, 0);
    checkOutput("rst_maddr", maddr, 0);
    checkOutput("rst_mwdata", mwdata, 0);
    checkOutput("rst_istall", istall, 1);
    checkOutput("rst_dstall", dstall, 0);
    checkOutput("rst_irdata", irdata, 0);
    checkOutput("rst_drdata", drdata, 0);
    applyStimulus(0, 1, 1, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("f0_mreq", mreq, 1);
    checkOutput("f0_istall", istall, 0);
    checkOutput("f0_irdata", irdata, 32'h2002_0005);
    checkOutput("f0_maddr", maddr, 0);

    // Fetch 0x4 and load 0x40 together: data first, then fetch.
    applyStimulus(0, 0, 1, 32'h4, 1, 0, 32'h40, 32'h0);
    checkOutput("both_idle_istall", istall, 1);
    checkOutput("both_idle_dstall", dstall, 1);
    checkOutput("both_idle_mreq", mreq, 0);
    applyStimulus(0, 0, 1, 32'h4, 1, 0, 32'h40, 32'h0);
    checkOutput("ld_mreq", mreq, 1);
    checkOutput("ld_maddr", maddr, 32'h40);
    checkOutput("ld_mwe", mwe, 0);
    checkOutput("ld_drdata", drdata, 32'hDEAD_BEEF);
    checkOutput("ld_dstall", dstall, 0);
    checkOutput("ld_istall", istall, 1);
    applyStimulus(0, 1, 1, 32'h4, 1, 0, 32'h40, 32'h0);
    checkOutput("f4_maddr", maddr, 32'h4);
    checkOutput("f4_irdata", irdata, 32'h0000_1001);
    checkOutput("f4_istall", istall, 0);
    checkOutput("f4_dstall", dstall, 0);
    checkOutput("f4_drdata_buf", drdata, 32'hDEAD_BEEF);

    // Store to 0x80 with advance held low afterwards: exactly one write.
    applyStimulus(0, 0, 1, 32'h8, 1, 1, 32'h80, 32'h1234_5678);
    checkOutput("st_idle_mreq", mreq, 0);
    checkOutput("st_idle_dstall", dstall, 1);
    applyStimulus(0, 0, 1, 32'h8, 1, 1, 32'h80, 32'h1234_5678);
    checkOutput("st_mwe", mwe, 1);
    checkOutput("st_maddr", maddr, 32'h80);
    checkOutput("st_mwdata", mwdata, 32'h1234_5678);
    checkOutput("st_dstall", dstall, 0);
    applyStimulus(0, 0, 1, 32'h8, 1, 1, 32'h80, 32'h1234_5678);
    checkOutput("f8_mwe", mwe, 0);
    checkOutput("f8_maddr", maddr, 32'h8);
    checkOutput("f8_istall", istall, 0);
    checkOutput("f8_irdata", irdata, 32'h0000_1002);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 1, 32'h8, 1, 1, 32'h80, 32'h1234_5678);
      checkOutput("st_hold_mreq", mreq, 0);
      checkOutput("st_hold_dstall", dstall, 0);
    end
    checkOutput("st_write_count", writeCount, 1);
    applyStimulus(0, 1, 1, 32'h8, 1, 1, 32'h80, 32'h1234_5678);
    checkOutput("st_adv_istall", istall, 0);

    // Load back the stored word.
    applyStimulus(0, 0, 1, 32'hC, 1, 0, 32'h80, 32'h0);
    checkOutput("ldb_idle_dstall", dstall, 1);
    applyStimulus(0, 0, 1, 32'hC, 1, 0, 32'h80, 32'h0);
    checkOutput("ldb_drdata", drdata, 32'h1234_5678);
    checkOutput("ldb_mwe", mwe, 0);
    applyStimulus(0, 1, 1, 32'hC, 1, 0, 32'h80, 32'h0);
    checkOutput("fC_irdata", irdata, 32'h0000_1003);
    checkOutput("ldb_write_count", writeCount, 1);

    // L=3 fetch: four stalled cycles, then the bypassed result with advance.
    applyStimulus(0, 0, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    lat = 3;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) applyStimulus(0, 0, 1, 32'h10, 0, 0, 32'h0, 32'h0);
      checkOutput("l3_istall_hi", istall, 1);
    end
    applyStimulus(0, 1, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    checkOutput("l3_istall_lo", istall, 0);
    checkOutput("l3_irdata", irdata, 32'h0000_1004);

    // Advance cleared ivalid; then reset in the middle of a slow load.
    applyStimulus(0, 0, 1, 32'h14, 1, 0, 32'h40, 32'h0);
    checkOutput("l3_adv_ivalid_clr", istall, 1);
    checkOutput("pre_rst_dstall", dstall, 1);
    applyStimulus(0, 0, 1, 32'h14, 1, 0, 32'h40, 32'h0);
    checkOutput("dbusy_mreq", mreq, 1);
    checkOutput("dbusy_maddr", maddr, 32'h40);
    checkOutput("dbusy_dstall", dstall, 1);
    applyStimulus(1, 0, 1, 32'h14, 1, 0, 32'h40, 32'h0);
    applyStimulus(0, 0, 1, 32'h14, 1, 0, 32'h40, 32'h0);
    lat = 0;
    #1;
    checkOutput("rst_mid_mreq", mreq, 0);
    checkOutput("rst_mid_dstall", dstall, 1);
    checkOutput("rst_mid_istall", istall, 1);
    applyStimulus(0, 0, 1, 32'h14, 1, 0, 32'h40, 32'h0);
    checkOutput("rld_drdata", drdata, 32'hDEAD_BEEF);
    checkOutput("rld_dstall", dstall, 0);
    applyStimulus(0, 1, 1, 32'h14, 1, 0, 32'h40, 32'h0);
    checkOutput("f14_irdata", irdata, 32'h0000_1005);
    checkOutput("f14_istall", istall, 0);

    // Redirect: ireq drops during a slow fetch, result still buffered, then cleared.
    applyStimulus(0, 0, 1, 32'h18, 0, 0, 32'h0, 32'h0);
    lat = 3;
    #1;
    checkOutput("rd_idle_mreq", mreq, 0);
    applyStimulus(0, 0, 1, 32'h18, 0, 0, 32'h0, 32'h0);
    checkOutput("rd_mreq", mreq, 1);
    checkOutput("rd_maddr", maddr, 32'h18);
    applyStimulus(0, 0, 0, 32'h18, 0, 0, 32'h0, 32'h0);
    checkOutput("rd_drop_istall", istall, 0);
    checkOutput("rd_drop_mreq", mreq, 1);
    applyStimulus(0, 0, 0, 32'h18, 0, 0, 32'h0, 32'h0);
    checkOutput("rd_wait_mreq", mreq, 1);
    applyStimulus(0, 0, 0, 32'h18, 0, 0, 32'h0, 32'h0);
    checkOutput("rd_done_mready", mready, 1);
    checkOutput("rd_done_irdata", irdata, 32'h0000_1006);
    applyStimulus(0, 1, 0, 32'h18, 0, 0, 32'h0, 32'h0);
    checkOutput("rd_buf_irdata", irdata, 32'h0000_1006);
    checkOutput("rd_buf_mreq", mreq, 0);
    applyStimulus(0, 0, 1, 32'h1C, 0, 0, 32'h0, 32'h0);
    lat = 0;
    #1;
    checkOutput("rd_new_istall", istall, 1);
    checkOutput("rd_new_idle_mreq", mreq, 0);
    applyStimulus(0, 0, 1, 32'h1C, 0, 0, 32'h0, 32'h0);
    checkOutput("rd_new_mreq", mreq, 1);
    checkOutput("rd_new_maddr", maddr, 32'h1C);
    checkOutput("rd_new_irdata", irdata, 32'h0000_1007);
    checkOutput("rd_new_istall_lo", istall, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch port and its MEM-stage data port. Requests are serialised through a small FSM with data-over-instruction priority. Each completed response is held in a per-port buffer until the pipeline advances. Combinational stall outputs freeze the pipeline while either port's access is outstanding.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `advance`  in  1  high in a cycle where the pipeline registers load. Clears both response buffers at that edge.
- `ireq`  in  1  fetch request; tied high in normal operation.
- `iaddr`  in  AW  fetch address (pcF).
- `irdata`  out  DW  fetched instruction (instrF).
- `istall`  out  1  fetch not yet satisfied.
- `dreq`  in  1  MEM-stage load or store.
- `dwe`  in  1  store when high (memwriteM).
- `daddr`  in  AW  data address (aluoutM).
- `dwdata`  in  DW  store data (writedataM).
- `drdata`  out  DW  load data (readdataM).
- `dstall`  out  1  data access not yet satisfied.
- `mreq`  out  1  memory request, registered.
- `mwe`  out  1  memory write enable, registered.
- `maddr`  out  AW  memory address, registered.
- `mwdata`  out  DW  memory write data, registered.
- `mrdata`  in  DW  memory read data, valid when `mready` is high.
- `mready`  in  1  one-cycle completion pulse for the current request.

## Operation
- FSM states: IDLE, IBUSY, DBUSY.
- Response buffers: `ibuf`/`ivalid` and `dbuf`/`dvalid`.
- Pending conditions:
  - ipend = `ireq` & !`ivalid`
  - dpend = `dreq` & !`dvalid`
- IDLE:
  - dpend → DBUSY, loading `maddr`=`daddr`, `mwe`=`dwe`, `mwdata`=`dwdata`.
  - Otherwise ipend → IBUSY, loading `maddr`=`iaddr`, `mwe`=0.
  - Otherwise stay in IDLE.
- DBUSY or IBUSY with `mready` low: hold state and all registered memory outputs.
- On `mready` high in either busy state:
  - Write the owning buffer (`mrdata`) and set its valid bit.
  - Select the next state: pending data (other than the access just finishing) → DBUSY; else pending instruction (other than the one just finishing) → IBUSY; else IDLE.
  - The next request's outputs load at the same edge, giving back-to-back issue with no IDLE bubble.
- `mreq` = 1 exactly when the state is IBUSY or DBUSY.
- Stores also set `dvalid` on completion; `drdata` is don't-care for stores.
- Stall outputs (combinational):
  - `istall` = ipend & !(IBUSY & `mready`)
  - `dstall` = dpend & !(DBUSY & `mready`)
- Read-data bypass (combinational):
  - `irdata` = (IBUSY & `mready`) ? `mrdata` : `ibuf`
  - `drdata` = (DBUSY & `mready`) ? `mrdata` : `dbuf`
- `advance` at an edge clears `ivalid` and `dvalid`. If a buffer write coincides with `advance`, the clear wins, because the bypassed value was consumed that cycle.
- An issued access always completes; there is no abort. If `ireq` drops during IBUSY, the result is still buffered and is cleared by the next `advance`.
- Requesters hold `iaddr`/`daddr`/`dwe`/`dwdata` stable while their stall output is high.

## Timing
- Reset values:
  - State IDLE; `ivalid`=`dvalid`=0.
  - `mreq`=`mwe`=0; `maddr`=`mwdata`=0; `ibuf`=`dbuf`=0.
  - With `ireq` high, `istall`=1 in the first cycle after reset.
- Request seen in IDLE at cycle t → `mreq` high from t+1. With `mready` at t+1+L, the stall drops combinationally in cycle t+1+L and the pipeline may advance at that edge.
- Minimum fetch cost with an L=0 memory: 2 cycles (IDLE decision cycle plus BUSY cycle).
- Fetch and load pending together: data is served first, then the fetch back-to-back. The fetch result is held in `ibuf` until `advance` if `dstall` is still high.
- Reset asserted in a busy state: return to IDLE next edge and drop `mreq`. The memory model must also be reset.
- No starvation: a data request exists only while the pipeline is stalled on it, so instruction requests are always served eventually.

## Structure
- Package `mem_arb_pkg`: `arb_state_t` enum {IDLE, IBUSY, DBUSY}; `AW`/`DW` defaults.
- Sub-module `mem_arb_buf`, instantiated twice (instruction and data): one-entry buffer containing the valid bit, data register, write/clear precedence and the bypass mux.
- Top level: FSM, registered memory request outputs, stall logic.

## Test plan
- After reset, `ireq`=1, `iaddr`=0x0, memory L=0 returns 0x2002_0005 → `mreq` high at cycle 1, `istall` low in cycle 1, `irdata`=0x2002_0005.
- Fetch 0x4 and load 0x40 (mem[0x40]=0xDEAD_BEEF) requested in the same cycle → DBUSY first, then IBUSY back-to-back. `drdata`=0xDEAD_BEEF; both stalls low only after the fetch completes.
- Store `daddr`=0x80, `dwdata`=0x1234_5678, with `advance` held low for 3 cycles after completion → one write (`mwe`=1 for exactly one request), no repeat issue. A following load of 0x80 returns 0x1234_5678.
- Memory L=3 fetch → `istall` high for 4 cycles, then low. `advance` at that edge leaves `ivalid`=0.
- Reset mid-DBUSY → next cycle state IDLE, `mreq`=0, `dvalid`=0, `dstall` reasserts while `dreq` is high.
- `ireq` dropped during IBUSY (redirect), then `advance` → response buffered, then cleared. The next `ireq` to a new address issues a fresh `mreq`.
